// File: rtl/cmd_sequencer.sv
// Command sequencer: decodes framed RX command bytes, drives the register
// file and ALU, and pushes response bytes into the TX FIFO.
module cmd_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int OP_WIDTH    = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic                    rf_wr_en,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic                    rf_rd_en,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_valid,
  output logic [OP_WIDTH-1:0]     alu_fun,
  output logic                    alu_en,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_valid,
  output logic                    clk_gate_en,
  output logic [DATA_WIDTH-1:0]   fifo_wr_data,
  output logic                    fifo_wr_en,
  input  logic                    fifo_full,
  output logic                    cmd_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYC - 1);

  localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_RUN = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR,
    RD_WAIT, ALU_A, ALU_B, ALU_FUN,
    ALU_RUN, PUSH_RD, PUSH_LO, PUSH_HI
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    kick;
  logic [DATA_WIDTH-1:0]   rd_byte;
  logic [2*DATA_WIDTH-1:0] result;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      cnt          <= '0;
      kick         <= 1'b0;
      rd_byte      <= '0;
      result       <= '0;
      rf_addr      <= '0;
      rf_wr_en     <= 1'b0;
      rf_wr_data   <= '0;
      rf_rd_en     <= 1'b0;
      alu_fun      <= '0;
      alu_en       <= 1'b0;
      clk_gate_en  <= 1'b0;
      fifo_wr_data <= '0;
      fifo_wr_en   <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      alu_en     <= 1'b0;
      fifo_wr_en <= 1'b0;
      cmd_err    <= 1'b0;
      case (state)
        IDLE: if (rx_valid) begin
          unique case (1'b1)
            rx_data == OP_WR:  state <= WR_ADDR;
            rx_data == OP_RD:  state <= RD_ADDR;
            rx_data == OP_ALU: state <= ALU_A;
            rx_data == OP_RUN: state <= ALU_FUN;
            default:           cmd_err <= 1'b1;
          endcase
        end
        WR_ADDR: if (rx_valid) begin
          rf_addr <= rx_data[ADDR_WIDTH-1:0];
          state   <= WR_DATA;
        end
        WR_DATA: if (rx_valid) begin
          rf_wr_en   <= 1'b1;
          rf_wr_data <= rx_data;
          state      <= IDLE;
        end
        RD_ADDR: if (rx_valid) begin
          rf_addr  <= rx_data[ADDR_WIDTH-1:0];
          rf_rd_en <= 1'b1;
          cnt      <= RELOAD;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (rx_valid) cmd_err <= 1'b1;
          if (rf_rd_valid) begin
            rd_byte <= rf_rd_data;
            state   <= PUSH_RD;
          end else if (cnt == '0) begin
            cmd_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ALU_A: if (rx_valid) begin
          rf_addr    <= '0;
          rf_wr_en   <= 1'b1;
          rf_wr_data <= rx_data;
          state      <= ALU_B;
        end
        ALU_B: if (rx_valid) begin
          rf_addr    <= ADDR_WIDTH'(1);
          rf_wr_en   <= 1'b1;
          rf_wr_data <= rx_data;
          state      <= ALU_FUN;
        end
        ALU_FUN: if (rx_valid) begin
          alu_fun     <= rx_data[OP_WIDTH-1:0];
          clk_gate_en <= 1'b1;
          kick        <= 1'b1;
          state       <= ALU_RUN;
        end
        ALU_RUN: begin
          if (rx_valid) cmd_err <= 1'b1;
          // first cycle here only fires alu_en; the clock is already ungated
          if (kick) begin
            kick   <= 1'b0;
            alu_en <= 1'b1;
            cnt    <= RELOAD;
          end else if (alu_out_valid) begin
            result      <= alu_out;
            clk_gate_en <= 1'b0;
            state       <= PUSH_LO;
          end else if (cnt == '0) begin
            cmd_err     <= 1'b1;
            clk_gate_en <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PUSH_RD: begin
          if (rx_valid) cmd_err <= 1'b1;
          if (!fifo_full) begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= rd_byte;
            state        <= IDLE;
          end
        end
        PUSH_LO: begin
          if (rx_valid) cmd_err <= 1'b1;
          if (!fifo_full) begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= result[DATA_WIDTH-1:0];
            state        <= PUSH_HI;
          end
        end
        PUSH_HI: begin
          if (rx_valid) cmd_err <= 1'b1;
          if (!fifo_full) begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= result[2*DATA_WIDTH-1:DATA_WIDTH];
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: RF/ALU/FIFO responders plus a command-level
// reference model of register contents and expected response bytes.
module tb_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [3:0]  rf_addr;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_data;
  logic        rf_rd_en;
  logic [7:0]  rf_rd_data = 8'h00;
  logic        rf_rd_valid = 1'b0;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic [15:0] alu_out = 16'h0000;
  logic        alu_out_valid = 1'b0;
  logic        clk_gate_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_wr_en;
  logic        fifo_full = 1'b0;
  logic        cmd_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  cmd_sequencer dut (
    .CLK(CLK), .RST(RST),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
    .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .clk_gate_en(clk_gate_en),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .cmd_err(cmd_err)
  );

  function automatic logic [15:0] alu_f(input logic [7:0] a, b,
                                        input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {8'h00, a & b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  // environment knobs
  bit rd_on = 1'b1;
  int rd_lat = 0;
  int alu_lat = 0;
  bit rand_full = 1'b0;
  bit force_full = 1'b0;

  // register file as seen by the hardware
  logic [7:0] rf_mem [16] = '{default: 8'h00};
  always @(posedge CLK) if (rf_wr_en) rf_mem[rf_addr] <= rf_wr_data;

  always begin : rd_rsp
    logic [3:0] a;
    @(negedge CLK);
    if (rf_rd_en && rd_on) begin
      a = rf_addr;
      repeat (rd_lat) @(negedge CLK);
      rf_rd_data  = rf_mem[a];
      rf_rd_valid = 1'b1;
      @(negedge CLK);
      rf_rd_valid = 1'b0;
    end
  end

  always begin : alu_rsp
    logic [15:0] r;
    @(negedge CLK);
    if (alu_en) begin
      r = alu_f(rf_mem[0], rf_mem[1], alu_fun);
      repeat (alu_lat) @(negedge CLK);
      alu_out       = r;
      alu_out_valid = 1'b1;
      @(negedge CLK);
      alu_out_valid = 1'b0;
    end
  end

  always @(negedge CLK)
    fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : force_full;

  // observed activity
  logic [7:0]  act_push[$];
  logic [11:0] act_wr[$];
  logic [3:0]  act_rd[$];
  int err_cnt = 0;
  int full_viol = 0;
  int gate_viol = 0;
  logic full_s = 1'b0;
  logic gate_prev = 1'b0;

  always @(posedge CLK) full_s <= fifo_full;

  always @(negedge CLK) begin
    if (fifo_wr_en) begin
      act_push.push_back(fifo_wr_data);
      if (full_s) full_viol++;
    end
    if (rf_wr_en) act_wr.push_back({rf_addr, rf_wr_data});
    if (rf_rd_en) act_rd.push_back(rf_addr);
    if (cmd_err) err_cnt++;
    if (alu_en && !gate_prev) gate_viol++;
    gate_prev = clk_gate_en;
  end

  // reference model
  logic [7:0]  ref_rf [16] = '{default: 8'h00};
  logic [7:0]  exp_push[$];
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  int exp_err = 0;
  int pp = 0, wp = 0, rp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLK);
    #1 rx_valid = 1'b0;
  endtask

  task automatic cmd_wr(input logic [7:0] a, d);
    send(8'hAA); send(a); send(d);
    ref_rf[a[3:0]] = d;
    exp_wr.push_back({a[3:0], d});
  endtask

  task automatic cmd_rd(input logic [7:0] a);
    send(8'hBB); send(a);
    exp_rd.push_back(a[3:0]);
    if (rd_on) exp_push.push_back(ref_rf[a[3:0]]);
    else exp_err++;
  endtask

  task automatic push_res(input logic [15:0] r);
    exp_push.push_back(r[7:0]);
    exp_push.push_back(r[15:8]);
  endtask

  task automatic cmd_alu(input logic [7:0] a, b, f);
    send(8'hCC); send(a); send(b); send(f);
    ref_rf[0] = a;
    ref_rf[1] = b;
    exp_wr.push_back({4'd0, a});
    exp_wr.push_back({4'd1, b});
    push_res(alu_f(a, b, f[3:0]));
  endtask

  task automatic cmd_run(input logic [7:0] f);
    send(8'hDD); send(f);
    push_res(alu_f(ref_rf[0], ref_rf[1], f[3:0]));
  endtask

  task automatic settle(input string tag);
    chk({tag, " push count"}, act_push.size(), exp_push.size());
    for (int i = pp; i < act_push.size() && i < exp_push.size(); i++)
      chk({tag, " push byte"}, act_push[i], exp_push[i]);
    pp = act_push.size();
    chk({tag, " wr count"}, act_wr.size(), exp_wr.size());
    for (int i = wp; i < act_wr.size() && i < exp_wr.size(); i++)
      chk({tag, " wr addr/data"}, act_wr[i], exp_wr[i]);
    wp = act_wr.size();
    chk({tag, " rd count"}, act_rd.size(), exp_rd.size());
    for (int i = rp; i < act_rd.size() && i < exp_rd.size(); i++)
      chk({tag, " rd addr"}, act_rd[i], exp_rd[i]);
    rp = act_rd.size();
    chk({tag, " cmd_err count"}, err_cnt, exp_err);
    chk({tag, " push while full"}, full_viol, 0);
    chk({tag, " alu_en before gate"}, gate_viol, 0);
    chk({tag, " gate idle"}, clk_gate_en, 1'b0);
  endtask

  function automatic logic [31:0] outs();
    return 32'({rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_fun, alu_en,
                clk_gate_en, fifo_wr_data, fifo_wr_en, cmd_err});
  endfunction

  initial begin
    int n;
    int kind;
    logic [7:0] b;
    RST      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset outputs", outs(), 32'h0);
    RST = 1'b1;
    idle(2);

    cmd_wr(8'h05, 8'h3C);
    idle(10);
    settle("write 05");

    cmd_rd(8'h05);
    idle(15);
    settle("read 05");

    alu_lat = 2;
    cmd_alu(8'h10, 8'h20, 8'h00);
    idle(15);
    settle("alu add");

    // result ready while the FIFO is full: nothing may be pushed
    force_full = 1'b1;
    alu_lat = 0;
    cmd_run(8'h00);
    idle(5);
    chk("held while full", act_push.size(), pp);
    force_full = 1'b0;
    idle(10);
    settle("run while full");

    send(8'h7E);
    exp_err++;
    idle(3);
    cmd_rd(8'h05);
    idle(15);
    settle("bad opcode");

    rd_on = 1'b0;
    cmd_rd(8'h03);
    n = 0;
    while (!cmd_err && n < 60) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("timeout latency", n, 16);
    idle(4);
    rd_on = 1'b1;
    settle("read timeout");

    rd_lat = 5;
    cmd_rd(8'hF5);
    send(8'h5A);
    exp_err++;
    idle(20);
    settle("dropped byte");

    // reset in ALU_B: the A write stands, nothing of the command survives
    send(8'hCC); send(8'h11);
    ref_rf[0] = 8'h11;
    exp_wr.push_back({4'd0, 8'h11});
    idle(1);
    RST = 1'b0;
    #1;
    chk("mid reset outputs", outs(), 32'h0);
    idle(2);
    RST = 1'b1;
    cmd_wr(8'h01, 8'hFF);
    idle(20);
    settle("after reset");

    rand_full = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rd_lat  = $urandom_range(0, 5);
      alu_lat = $urandom_range(0, 5);
      kind    = $urandom_range(0, 4);
      case (kind)
        0: cmd_wr(8'($urandom), 8'($urandom));
        1: cmd_rd(8'($urandom));
        2: cmd_alu(8'($urandom), 8'($urandom), 8'($urandom));
        3: cmd_run(8'($urandom));
        default: begin
          b = 8'($urandom);
          while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD)
            b = 8'($urandom);
          send(b);
          exp_err++;
        end
      endcase
      idle(30);
      settle("random");
    end
    rand_full = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
